// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, data widths and the arbiter FSM state encoding.
package alu_pkg;

    localparam int unsigned OPW  = 5;
    localparam int unsigned XLEN = 32;

    localparam logic [OPW-1:0] OpAdd  = 5'd0;
    localparam logic [OPW-1:0] OpSub  = 5'd1;
    localparam logic [OPW-1:0] OpSll  = 5'd2;
    localparam logic [OPW-1:0] OpSlt  = 5'd3;
    localparam logic [OPW-1:0] OpSltu = 5'd4;
    localparam logic [OPW-1:0] OpXor  = 5'd5;
    localparam logic [OPW-1:0] OpSrl  = 5'd6;
    localparam logic [OPW-1:0] OpSra  = 5'd7;
    localparam logic [OPW-1:0] OpOr   = 5'd8;
    localparam logic [OPW-1:0] OpAnd  = 5'd9;
    localparam logic [OPW-1:0] OpEq   = 5'd10;
    localparam logic [OPW-1:0] OpNeq  = 5'd11;
    localparam logic [OPW-1:0] OpLt   = 5'd12;
    localparam logic [OPW-1:0] OpGe   = 5'd13;
    localparam logic [OPW-1:0] OpLtu  = 5'd14;
    localparam logic [OPW-1:0] OpGeu  = 5'd15;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between NREQ requesters and the ALU arbiter.
interface alu_arbiter_if #(
    parameter int unsigned NREQ = 2
);
    import alu_pkg::*;

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*OPW-1:0]  req_op;
    logic [NREQ*XLEN-1:0] req_lhs;
    logic [NREQ*XLEN-1:0] req_rhs;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready;
    logic [XLEN-1:0]      rsp_data;

    // Requester side.
    modport master (
        output req_valid, req_op, req_lhs, req_rhs, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_op, req_lhs, req_rhs, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/alu.sv
// Single-cycle combinational ALU. Undefined op codes produce 0.
module alu
    import alu_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [OPW-1:0]  op_i,
    input  logic [XLEN-1:0] lhs_i,
    input  logic [XLEN-1:0] rhs_i,
    output logic [XLEN-1:0] res_o
);

    // Clock/reset kept for pin compatibility with pipelined ALU variants.
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;

    // Decode op and compute result.
    always_comb begin
        res_o = '0;
        case (op_i)
            OpAdd:  res_o = lhs_i + rhs_i;
            OpSub:  res_o = lhs_i - rhs_i;
            OpSll:  res_o = lhs_i << rhs_i[4:0];
            OpSlt:  res_o = XLEN'($signed(lhs_i) < $signed(rhs_i));
            OpSltu: res_o = XLEN'(lhs_i < rhs_i);
            OpXor:  res_o = lhs_i ^ rhs_i;
            OpSrl:  res_o = lhs_i >> rhs_i[4:0];
            OpSra:  res_o = XLEN'($signed(lhs_i) >>> rhs_i[4:0]);
            OpOr:   res_o = lhs_i | rhs_i;
            OpAnd:  res_o = lhs_i & rhs_i;
            OpEq:   res_o = XLEN'(lhs_i == rhs_i);
            OpNeq:  res_o = XLEN'(lhs_i != rhs_i);
            OpLt:   res_o = XLEN'($signed(lhs_i) < $signed(rhs_i));
            OpGe:   res_o = XLEN'($signed(lhs_i) >= $signed(rhs_i));
            OpLtu:  res_o = XLEN'(lhs_i < rhs_i);
            OpGeu:  res_o = XLEN'(lhs_i >= rhs_i);
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after last_i, with wrap-around.
module rr_pick #(
    parameter  int unsigned NREQ = 2,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_i,
    output logic            found_o,
    output logic [IDW-1:0]  idx_o
);

    int cand;

    // Scan farthest candidate first so the nearest one after last_i is written last and wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = (int'(last_i) + k) % int'(NREQ);
            if (req_i[cand[IDW-1:0]]) begin
                found_o = 1'b1;
                idx_o   = cand[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ requesters.
// Accept in IDLE (or on a RESP handshake), one EXEC cycle, then hold the result in RESP.
// Optional: ALU_ARB_PERF_EN adds per-requester 32-bit accept counters on perf_grant_cnt.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic               CLK,
    input  logic               RST,
    alu_arbiter_if.slave       bus,
    output logic               busy
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [NREQ*XLEN-1:0] perf_grant_cnt
`endif
);

    localparam int unsigned IDW = $clog2(NREQ);

    arb_state_e      state_q, state_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [IDW-1:0]  gnt_q, gnt_d;
    logic [OPW-1:0]  op_q, op_d;
    logic [XLEN-1:0] lhs_q, lhs_d;
    logic [XLEN-1:0] rhs_q, rhs_d;
    logic [XLEN-1:0] rsp_q, rsp_d;
    logic [XLEN-1:0] alu_res;

    logic            rsp_hs;
    logic            accept;
    logic [IDW-1:0]  pick_last;
    logic            pick_found;
    logic [IDW-1:0]  pick_idx;

    // A response handshake advances the pointer before arbitrating in the same cycle.
    assign rsp_hs    = (state_q == StResp) && bus.rsp_ready[gnt_q];
    assign pick_last = rsp_hs ? gnt_q : last_q;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req_i   (bus.req_valid),
        .last_i  (pick_last),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    alu u_alu (
        .clk_i  (CLK),
        .rst_ni (~RST),
        .op_i   (op_q),
        .lhs_i  (lhs_q),
        .rhs_i  (rhs_q),
        .res_o  (alu_res)
    );

    // Next-state logic: accept, execute, respond.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        op_d    = op_q;
        lhs_d   = lhs_q;
        rhs_d   = rhs_q;
        rsp_d   = rsp_q;
        accept  = 1'b0;
        case (state_q)
            StIdle: accept = pick_found;
            StExec: begin
                rsp_d   = alu_res;
                state_d = StResp;
            end
            StResp: begin
                if (rsp_hs) begin
                    last_d = gnt_q;
                    accept = pick_found;
                    if (!pick_found) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // No accept while reset is held, even though the state reads IDLE.
        if (RST) begin
            accept = 1'b0;
        end
        if (accept) begin
            gnt_d   = pick_idx;
            op_d    = bus.req_op[int'(pick_idx) * OPW +: OPW];
            lhs_d   = bus.req_lhs[int'(pick_idx) * XLEN +: XLEN];
            rhs_d   = bus.req_rhs[int'(pick_idx) * XLEN +: XLEN];
            state_d = StExec;
        end
    end

    // Handshake outputs decoded from state and grant.
    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        if (accept) begin
            bus.req_ready[pick_idx] = 1'b1;
        end
        if (state_q == StResp) begin
            bus.rsp_valid[gnt_q] = 1'b1;
        end
    end

    assign bus.rsp_data = rsp_q;
    assign busy         = (state_q != StIdle);

    // State and operand registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            last_q  <= IDW'(NREQ - 1);
            gnt_q   <= '0;
            op_q    <= '0;
            lhs_q   <= '0;
            rhs_q   <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            op_q    <= op_d;
            lhs_q   <= lhs_d;
            rhs_q   <= rhs_d;
            rsp_q   <= rsp_d;
        end
    end

`ifdef ALU_ARB_PERF_EN
    logic [NREQ-1:0][XLEN-1:0] perf_cnt_q;

    // Per-requester accept counters, wrapping at 2^32.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            perf_cnt_q <= '0;
        end else if (accept) begin
            perf_cnt_q[pick_idx] <= perf_cnt_q[pick_idx] + XLEN'(1);
        end
    end

    assign perf_grant_cnt = perf_cnt_q;
`else
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a 2-requester and a 4-requester instance.
module tb_alu_arbiter;
    import alu_pkg::*;

    typedef struct {
        int unsigned idx;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy2, busy4;
    int   nvec = 0;
    int   nerr = 0;
    exp_t q2[$];
    exp_t q4[$];
    exp_t e2, e4;

    always #5 clk = ~clk;

    alu_arbiter_if #(.NREQ(2)) if2 ();
    alu_arbiter_if #(.NREQ(4)) if4 ();

`ifdef ALU_ARB_PERF_EN
    logic [63:0]  perf2;
    logic [127:0] perf4;
`endif

    alu_arbiter #(.NREQ(2)) dut2 (
        .CLK  (clk),
        .RST  (rst),
        .bus  (if2),
        .busy (busy2)
`ifdef ALU_ARB_PERF_EN
        ,
        .perf_grant_cnt (perf2)
`endif
    );

    alu_arbiter #(.NREQ(4)) dut4 (
        .CLK  (clk),
        .RST  (rst),
        .bus  (if4),
        .busy (busy4)
`ifdef ALU_ARB_PERF_EN
        ,
        .perf_grant_cnt (perf4)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit on4, input int unsigned idx, input logic [31:0] data);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        if (on4) q4.push_back(e);
        else     q2.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while ((q2.size() != 0 || q4.size() != 0 || busy2 || busy4) && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", 32'(n < 30), 32'd1);
    endtask

    // One isolated request on either instance, then wait for its response.
    task automatic issue(input bit on4, input int idx, input logic [4:0] op,
                         input logic [31:0] lhs, input logic [31:0] rhs, input logic [31:0] exp);
        int  n = 0;
        logic rdy;
        tick();
        if (on4) begin
            if4.req_valid[idx] = 1'b1;
            if4.req_op[idx*5 +: 5] = op;
            if4.req_lhs[idx*32 +: 32] = lhs;
            if4.req_rhs[idx*32 +: 32] = rhs;
        end else begin
            if2.req_valid[idx] = 1'b1;
            if2.req_op[idx*5 +: 5] = op;
            if2.req_lhs[idx*32 +: 32] = lhs;
            if2.req_rhs[idx*32 +: 32] = rhs;
        end
        @(negedge clk);
        rdy = on4 ? if4.req_ready[idx] : if2.req_ready[idx];
        while (!rdy && n < 10) begin
            @(negedge clk);
            rdy = on4 ? if4.req_ready[idx] : if2.req_ready[idx];
            n++;
        end
        chk("issue_accept", on4 ? 32'(if4.req_ready) : 32'(if2.req_ready), 32'(1) << idx);
        if (rdy) push(on4, idx, exp);
        tick();
        if (on4) if4.req_valid[idx] = 1'b0;
        else     if2.req_valid[idx] = 1'b0;
        drain();
    endtask

    // Scoreboard monitor, 2-requester instance: compare on each response handshake.
    always @(negedge clk) begin
        if (!rst && (if2.rsp_valid & if2.rsp_ready) != 2'b00) begin
            nvec++;
            if (q2.size() == 0) begin
                nerr++;
                $display("FAIL d2_unexpected_rsp: got valid=%b data=%h, required none",
                         if2.rsp_valid, if2.rsp_data);
            end else begin
                e2 = q2.pop_front();
                if (if2.rsp_valid !== (2'b01 << e2.idx) || if2.rsp_data !== e2.data) begin
                    nerr++;
                    $display("FAIL d2_rsp: got valid=%b data=%h, required valid=%b data=%h",
                             if2.rsp_valid, if2.rsp_data, 2'b01 << e2.idx, e2.data);
                end
            end
        end
    end

    // Scoreboard monitor, 4-requester instance.
    always @(negedge clk) begin
        if (!rst && (if4.rsp_valid & if4.rsp_ready) != 4'b0000) begin
            nvec++;
            if (q4.size() == 0) begin
                nerr++;
                $display("FAIL d4_unexpected_rsp: got valid=%b data=%h, required none",
                         if4.rsp_valid, if4.rsp_data);
            end else begin
                e4 = q4.pop_front();
                if (if4.rsp_valid !== (4'b0001 << e4.idx) || if4.rsp_data !== e4.data) begin
                    nerr++;
                    $display("FAIL d4_rsp: got valid=%b data=%h, required valid=%b data=%h",
                             if4.rsp_valid, if4.rsp_data, 4'b0001 << e4.idx, e4.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] rdy_seq [7];
        rdy_seq = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};

        if2.req_valid = 2'b11;
        if2.req_op    = '0;
        if2.req_lhs   = '0;
        if2.req_rhs   = '0;
        if2.rsp_ready = 2'b11;
        if4.req_valid = '0;
        if4.req_op    = '0;
        if4.req_lhs   = '0;
        if4.req_rhs   = '0;
        if4.rsp_ready = 4'b1111;

        // Reset state, with requests pending during reset.
        #12;
        chk("rst_req_ready", 32'(if2.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(if2.rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy2), 32'd0);
        chk("rst_rsp_data", if2.rsp_data, 32'd0);
        chk("rst_d4_busy", 32'(busy4), 32'd0);
        tick();
        rst = 1'b0;
        if2.req_valid = 2'b00;

        // Single request: ADD 5+7, latency and busy window.
        tick();
        if2.req_valid = 2'b01;
        if2.req_op[4:0] = OpAdd;
        if2.req_lhs[31:0] = 32'd5;
        if2.req_rhs[31:0] = 32'd7;
        @(negedge clk);
        chk("t1_ready_same_cycle", 32'(if2.req_ready), 32'd1);
        chk("t1_busy_accept", 32'(busy2), 32'd0);
        push(1'b0, 0, 32'd12);
        tick();
        if2.req_valid = 2'b00;
        @(negedge clk);
        chk("t1_busy_exec", 32'(busy2), 32'd1);
        chk("t1_no_rsp_exec", 32'(if2.rsp_valid), 32'd0);
        @(negedge clk);
        chk("t1_rsp_valid", 32'(if2.rsp_valid), 32'd1);
        chk("t1_busy_resp", 32'(busy2), 32'd1);
        @(negedge clk);
        chk("t1_busy_after", 32'(busy2), 32'd0);

        // Contention: fresh reset, both valid, grants alternate 0,1,0,1.
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if2.req_valid = 2'b11;
        if2.req_op = {OpSra, OpSub};
        if2.req_lhs = {32'h8000_0000, 32'd10};
        if2.req_rhs = {32'd4, 32'd3};
        push(1'b0, 0, 32'd7);
        push(1'b0, 1, 32'hF800_0000);
        push(1'b0, 0, 32'd7);
        push(1'b0, 1, 32'hF800_0000);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("t2_ready_seq", 32'(if2.req_ready), 32'(rdy_seq[i]));
        end
        tick();
        if2.req_valid = 2'b00;
        drain();

        // Backpressure on requester 0; requester 1 waits and its rsp_ready is ignored.
        tick();
        if2.rsp_ready = 2'b10;
        if2.req_valid = 2'b01;
        if2.req_op = {OpAdd, OpSlt};
        if2.req_lhs = {32'd1, 32'hFFFF_FFFF};
        if2.req_rhs = {32'd2, 32'd1};
        @(negedge clk);
        chk("t3_accept0", 32'(if2.req_ready), 32'd1);
        push(1'b0, 0, 32'd1);
        tick();
        if2.req_valid = 2'b10;
        @(negedge clk);
        chk("t3_no_ready_exec", 32'(if2.req_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", 32'(if2.rsp_valid), 32'd1);
            chk("t3_hold_data", if2.rsp_data, 32'd1);
            chk("t3_no_ready_wait", 32'(if2.req_ready), 32'd0);
        end
        tick();
        if2.rsp_ready = 2'b11;
        @(negedge clk);
        chk("t3_back_to_back", 32'(if2.req_ready), 32'd2);
        push(1'b0, 1, 32'd3);
        tick();
        if2.req_valid = 2'b00;
        drain();

        // Wrap-around on the 4-requester instance (pointer at 3 after reset).
        tick();
        if4.req_valid = 4'b1001;
        if4.req_op[4:0] = OpXor;
        if4.req_lhs[31:0] = 32'hF0F0_F0F0;
        if4.req_rhs[31:0] = 32'h0FF0_0FF0;
        if4.req_op[19:15] = OpSll;
        if4.req_lhs[127:96] = 32'd1;
        if4.req_rhs[127:96] = 32'd31;
        @(negedge clk);
        chk("t4_wrap_to_0", 32'(if4.req_ready), 32'h1);
        push(1'b1, 0, 32'hFF00_FF00);
        @(negedge clk);
        chk("t4_no_ready_exec", 32'(if4.req_ready), 32'h0);
        @(negedge clk);
        chk("t4_next_is_3", 32'(if4.req_ready), 32'h8);
        push(1'b1, 3, 32'h8000_0000);
        tick();
        if4.req_valid = 4'b0000;
        drain();
        issue(1'b1, 1, 5'd31, 32'd7, 32'd7, 32'd0);
        issue(1'b1, 2, OpSrl, 32'h8000_0000, 32'd4, 32'h0800_0000);

        // Reset during EXEC: in-flight request of requester 1 is dropped.
        tick();
        if2.req_valid = 2'b10;
        if2.req_op[9:5] = OpAdd;
        if2.req_lhs[63:32] = 32'd100;
        if2.req_rhs[63:32] = 32'd1;
        @(negedge clk);
        chk("t5_accept1", 32'(if2.req_ready), 32'd2);
        tick();
        rst = 1'b1;
        #1;
        chk("t5_busy_drop", 32'(busy2), 32'd0);
        chk("t5_rsp_drop", 32'(if2.rsp_valid), 32'd0);
        chk("t5_no_ready_rst", 32'(if2.req_ready), 32'd0);
        tick();
        rst = 1'b0;
        if2.req_valid = 2'b11;
        if2.req_op[4:0] = OpAnd;
        if2.req_lhs[31:0] = 32'hFF00_FF00;
        if2.req_rhs[31:0] = 32'h0F0F_0F0F;
        @(negedge clk);
        chk("t5_first_grant0", 32'(if2.req_ready), 32'd1);
        push(1'b0, 0, 32'h0F00_0F00);
        tick();
        if2.req_valid = 2'b00;
        drain();

        // Further accepts: requester 0 reaches 3 since reset, requester 1 reaches 2.
        issue(1'b0, 1, OpSub, 32'd0, 32'd1, 32'hFFFF_FFFF);
        issue(1'b0, 0, OpEq, 32'd5, 32'd5, 32'd1);
        issue(1'b0, 1, OpLtu, 32'd1, 32'd2, 32'd1);
        issue(1'b0, 0, OpGe, 32'hFFFF_FFFF, 32'd0, 32'd0);

`ifdef ALU_ARB_PERF_EN
        chk("perf_cnt0", perf2[31:0], 32'd3);
        chk("perf_cnt1", perf2[63:32], 32'd2);
        force dut2.perf_cnt_q = '1;
        #1;
        release dut2.perf_cnt_q;
        issue(1'b0, 0, OpNeq, 32'd1, 32'd2, 32'd1);
        chk("perf_wrap0", perf2[31:0], 32'd0);
        chk("perf_hold1", perf2[63:32], 32'hFFFF_FFFF);
`endif

        chk("queues_empty", 32'(q2.size() + q4.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
